// File: rtl/alu_pkg.sv
// Shared types for the ALU and its two-port arbiter.
// Opcodes, flag bundle layout and arbiter FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_MUL = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_t;

    // Packed so that the 4-bit view reads {Z,C,V,S}.
    typedef struct packed {
        logic z;
        logic c;
        logic v;
        logic s;
    } alu_flags_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU with 8-bit result and {Z,C,V,S} flags.
// Ports: a_i, b_i operands; sel_i opcode; result_o; flags_o.
module alu
    import alu_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  op_t        sel_i,
    output logic [7:0] result_o,
    output alu_flags_t flags_o
);

    logic [4:0] diff;

    // Extra MSB carries the borrow out of the subtraction.
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        result_o  = '0;
        flags_o   = '0;
        unique case (sel_i)
            OP_MUL: begin
                result_o  = {4'b0, a_i} * {4'b0, b_i};
                flags_o.c = |result_o[7:4];
                flags_o.s = result_o[7];
            end
            OP_SUB: begin
                result_o  = {4'b0, diff[3:0]};
                flags_o.c = diff[4];
                // Signed overflow: operand signs differ and
                // the result sign differs from A.
                flags_o.v = (a_i[3] ^ b_i[3])
                          & (a_i[3] ^ diff[3]);
                flags_o.s = diff[3];
            end
            OP_AND: begin
                result_o  = {4'b0, a_i & b_i};
                flags_o.s = result_o[3];
            end
            OP_XOR: begin
                result_o  = {4'b0, a_i ^ b_i};
                flags_o.s = result_o[3];
            end
        endcase
        flags_o.z = (result_o == 8'd0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Ports: req_* in, rsp_* out, busy, per-port done_cnt.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0][3:0]       req_a,
    input  logic [N_REQ-1:0][3:0]       req_b,
    input  logic [N_REQ-1:0][1:0]       req_sel,
    output logic [N_REQ-1:0]            rsp_valid,
    input  logic [N_REQ-1:0]            rsp_ready,
    output logic [7:0]                  rsp_result,
    output alu_flags_t                  rsp_flags,
    output logic                        busy,
    output logic [N_REQ-1:0][CNT_W-1:0] done_cnt
);

    arb_state_t state_q, state_d;
    logic       prio_q, prio_d;
    logic       g_q, g_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    op_t        sel_q, sel_d;
    logic [7:0] res_q, res_d;
    alu_flags_t flg_q, flg_d;
    logic [N_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

    logic [7:0] alu_res;
    alu_flags_t alu_flg;
    logic       gnt_vld;
    logic       gnt_id;
    logic       rsp_fire;

    alu u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .sel_i    (sel_q),
        .result_o (alu_res),
        .flags_o  (alu_flg)
    );

    always_comb begin
        // A lone requester wins; a tie goes to prio_q.
        gnt_id = req_valid[1];
        if (&req_valid) gnt_id = prio_q;
        gnt_vld  = (state_q == IDLE) && (|req_valid);
        rsp_fire = (state_q == RESP) && rsp_ready[g_q];
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        g_d     = g_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        res_d   = res_q;
        flg_d   = flg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    g_d     = gnt_id;
                    a_d     = req_a[gnt_id];
                    b_d     = req_b[gnt_id];
                    sel_d   = op_t'(req_sel[gnt_id]);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_res;
                flg_d   = alu_flg;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_fire) begin
                    if (cnt_q[g_q] != '1)
                        cnt_d[g_q] = cnt_q[g_q] + CNT_W'(1);
                    prio_d  = ~g_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            g_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= OP_MUL;
            res_q   <= '0;
            flg_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            g_q     <= g_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (gnt_vld) req_ready[gnt_id] = 1'b1;
        if (state_q == RESP) rsp_valid[g_q] = 1'b1;
    end

    assign busy       = (state_q != IDLE);
    assign rsp_result = res_q;
    assign rsp_flags  = flg_q;
    assign done_cnt   = cnt_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

- Shares the single 4-bit `alu` between two requesters: the switch/button front end (port 0) and the UART command decoder (port 1).
- Each request carries operands and an opcode. The winner's request is registered, evaluated on the ALU, and the 8-bit result plus flags are captured and returned with a valid/ready response.
- Uses round-robin arbitration, one operation in flight at a time.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters. Only 2 is supported; it is a parameter for readability.
- `CNT_W`, 16: width of the per-port completed-operation counters.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous active-high reset
- `req_valid`  in  [1:0]  request present, one bit per port
- `req_ready`  out  [1:0]  request accepted this cycle, one-hot or zero
- `req_a`  in  [1:0][3:0]  operand A per port
- `req_b`  in  [1:0][3:0]  operand B per port
- `req_sel`  in  [1:0][1:0]  opcode per port (`op_t`)
- `rsp_valid`  out  [1:0]  response available for that port, one-hot or zero
- `rsp_ready`  in  [1:0]  port consumes response
- `rsp_result`  out  8  captured ALU result
- `rsp_flags`  out  4  captured flags, packed {Z,C,V,S}
- `busy`  out  1  high whenever state is not IDLE
- `done_cnt`  out  [1:0][CNT_W-1:0]  responses delivered per port, saturating

## Operation
- States: IDLE, EXEC, RESP.
- Operand registers `a_q`, `b_q`, `sel_q` feed the `alu` instance. Result and flag registers feed `rsp_result` and `rsp_flags`.
- Priority pointer `prio` (1 bit) names the port favoured on a tie.
- **IDLE:**
  - If exactly one `req_valid` is high, grant that port.
  - If both are high, grant `prio`.
  - `req_ready[g]` is driven combinationally high in the same cycle. The handshake completes that cycle.
  - On grant: latch operands and opcode, store grant id `g_q`, go to EXEC.
  - No valid request: stay in IDLE, `req_ready` = 0.
- **EXEC:** the ALU evaluates the registered operands. Capture `result` and {Z,C,V,S} into the response registers. Go to RESP.
- **RESP:**
  - `rsp_valid[g_q]` = 1. Result and flags are held stable until the port handshakes.
  - On `rsp_ready[g_q]`: increment `done_cnt[g_q]` (saturates at all-ones), set `prio = ~g_q`, go to IDLE.
  - `rsp_ready` on the non-granted port is ignored.
- Requests are never accepted outside IDLE. `req_ready` is 0 in EXEC and RESP, even if `req_valid` stays high.
- The arbiter does not reinterpret arithmetic or flags. Result width and flag meaning are exactly as `alu` produces them for `sel_q`.
- Fairness: a port that loses a tie wins the next tie. Neither port can be starved beyond one operation.
- `req_sel` values are all legal; there is no illegal-opcode path.

## Timing
- Reset values:
  - state IDLE, `prio` 0, `req_ready` 0, `rsp_valid` 0
  - `rsp_result` 0, `rsp_flags` 0, `busy` 0, `done_cnt` all 0
  - operand registers 0
- Latency: request accepted at edge N; `rsp_valid` is high from cycle N+2. With `rsp_ready` already high, the response completes at edge N+2.
- Minimum spacing between accepts is 3 cycles (IDLE, EXEC, RESP).
- Back-pressure: if `rsp_ready` is held low, the block stays in RESP indefinitely with outputs frozen.
- Simultaneous events:
  - A new `req_valid` during RESP is seen only once the block is back in IDLE. It is accepted one cycle after the response handshake.
  - A request and a response on the same port in the same cycle: the response completes, and the request waits for IDLE.
- Reset mid-operation (EXEC or RESP):
  - The operation is abandoned and no response is delivered.
  - `done_cnt` is not incremented.
  - All outputs return to reset values on the next edge.
- `done_cnt` at all-ones: stays at all-ones, with no wrap.

## Structure
- Package `alu_pkg` holds:
  - `op_t` enum: OP_MUL=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_XOR=2'b11
  - `alu_flags_t` packed struct {Z,C,V,S}
  - `arb_state_t` enum {IDLE, EXEC, RESP}
- The existing `alu` module is instantiated as the only sub-module, unchanged.
- Arbitration and the FSM live in `alu_arbiter` itself.

## Test plan
1. Port 0 only: A=15, B=3, sel=OP_MUL accepted at edge N -> `rsp_valid[0]` at N+2, `rsp_result`=8'd45, `done_cnt[0]`=1.
2. Both ports valid after reset: port 0 A=10, B=3, OP_SUB; port 1 A=7, B=2, OP_MUL -> port 0 granted first, result 8'd7. Port 1 is then accepted one cycle after that handshake, result 8'd14, and `prio` alternates.
3. Port 1 A=3, B=3, OP_SUB -> `rsp_result`=0, `rsp_flags.Z`=1. Then A=4'b1100, B=4'b0010, OP_XOR -> result 8'b0000_1110, Z=0.
4. Back-pressure: OP_AND on 4'b1100 and 4'b0010 with `rsp_ready` low for 5 cycles -> `rsp_valid` held, result 0 and Z=1 stable, `req_ready` stays 0 for a waiting port 0 request.
5. Reset asserted in EXEC -> next cycle all outputs at reset values, no `rsp_valid`, `done_cnt` unchanged at 0.
6. Saturation: preload or iterate with CNT_W=2, 5 port-0 operations -> `done_cnt[0]` sticks at 2'b11.
